// File: rtl/data_mem_scan_loader.sv
// Assembles BEAT_W-wide stream beats into 512-bit lines, writes them to the data
// memory over the scan path, then launches the compute loop and waits for it.
module data_mem_scan_loader #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic [7:0]                line_cnt_i,
    input  logic [3:0]                input_id_i,
    input  logic [7:0]                block_width_i,
    input  logic [7:0]                block_height_i,
    input  logic                      size_type_i,
    input  logic [BEAT_W-1:0]         beat_i,
    input  logic                      beat_valid_i,
    output logic                      beat_ready_o,
    output logic [BEAT_W*BEATS-1:0]   scan_in_o,
    output logic                      scan_mode_o,
    output logic [7:0]                scan_addr_o,
    output logic                      input_prepare_o,
    output logic [3:0]                input_id_o,
    output logic [7:0]                block_width_o,
    output logic [7:0]                block_height_o,
    output logic                      size_type_o,
    input  logic                      loop_finished_i,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int LINE_W = BEAT_W * BEATS;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_LAUNCH = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [7:0]        line_idx_q, line_idx_d;
    logic [7:0]        line_cnt_q, line_cnt_d;
    logic [BIDX_W-1:0] beat_idx_q, beat_idx_d;
    logic [LINE_W-1:0] line_buf_q, line_buf_d;
    logic [LINE_W-1:0] scan_in_q, scan_in_d;
    logic [7:0]        scan_addr_q, scan_addr_d;
    logic [3:0]        input_id_q, input_id_d;
    logic [7:0]        block_width_q, block_width_d;
    logic [7:0]        block_height_q, block_height_d;
    logic              size_type_q, size_type_d;

    always_comb begin
        state_d        = state_q;
        line_idx_d     = line_idx_q;
        line_cnt_d     = line_cnt_q;
        beat_idx_d     = beat_idx_q;
        line_buf_d     = line_buf_q;
        scan_in_d      = scan_in_q;
        scan_addr_d    = scan_addr_q;
        input_id_d     = input_id_q;
        block_width_d  = block_width_q;
        block_height_d = block_height_q;
        size_type_d    = size_type_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    input_id_d     = input_id_i;
                    block_width_d  = block_width_i;
                    block_height_d = block_height_i;
                    size_type_d    = size_type_i;
                    line_cnt_d     = line_cnt_i;
                    line_idx_d     = 8'd0;
                    beat_idx_d     = '0;
                    state_d        = S_FILL;
                end
            end
            S_FILL: begin
                if (beat_valid_i) begin
                    line_buf_d[beat_idx_q*BEAT_W +: BEAT_W] = beat_i;
                    // The output register takes the completed line so it holds until the next write.
                    if (beat_idx_q == LAST_BEAT) begin
                        scan_in_d   = line_buf_d;
                        scan_addr_d = line_idx_q;
                        state_d     = S_WRITE;
                    end else begin
                        beat_idx_d = beat_idx_q + BIDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (line_idx_q == line_cnt_q) begin
                    state_d = S_LAUNCH;
                end else begin
                    line_idx_d = line_idx_q + 8'd1;
                    beat_idx_d = '0;
                    state_d    = S_FILL;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (loop_finished_i) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            line_idx_q     <= 8'd0;
            line_cnt_q     <= 8'd0;
            beat_idx_q     <= '0;
            line_buf_q     <= '0;
            scan_in_q      <= '0;
            scan_addr_q    <= 8'd0;
            input_id_q     <= 4'd0;
            block_width_q  <= 8'd0;
            block_height_q <= 8'd0;
            size_type_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_idx_q     <= line_idx_d;
            line_cnt_q     <= line_cnt_d;
            beat_idx_q     <= beat_idx_d;
            line_buf_q     <= line_buf_d;
            scan_in_q      <= scan_in_d;
            scan_addr_q    <= scan_addr_d;
            input_id_q     <= input_id_d;
            block_width_q  <= block_width_d;
            block_height_q <= block_height_d;
            size_type_q    <= size_type_d;
        end
    end

    // All strobes decode the registered state, so beat_ready_o has no path from beat_valid_i.
    assign beat_ready_o    = (state_q == S_FILL);
    assign scan_mode_o     = (state_q == S_WRITE);
    assign input_prepare_o = (state_q == S_LAUNCH);
    assign done_o          = (state_q == S_DONE);
    assign busy_o          = (state_q != S_IDLE);
    assign scan_in_o       = scan_in_q;
    assign scan_addr_o     = scan_addr_q;
    assign input_id_o      = input_id_q;
    assign block_width_o   = block_width_q;
    assign block_height_o  = block_height_q;
    assign size_type_o     = size_type_q;

endmodule
